// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | alu_pkg: opcodes, flag indices, FSM states, CMP qualifier codes |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_MUL    = 5'd2;
  localparam logic [4:0] OP_DIV    = 5'd3;
  localparam logic [4:0] OP_CMP    = 5'd4;
  localparam logic [4:0] OP_AND    = 5'd5;
  localparam logic [4:0] OP_OR     = 5'd6;
  localparam logic [4:0] OP_XOR    = 5'd7;
  localparam logic [4:0] OP_NOT    = 5'd8;
  localparam logic [4:0] OP_NAND   = 5'd9;
  localparam logic [4:0] OP_NOR    = 5'd10;
  localparam logic [4:0] OP_XNOR   = 5'd11;
  localparam logic [4:0] OP_CL_MUL = 5'd12;

  localparam int FLG_OVF  = 0;
  localparam int FLG_UNF  = 1;
  localparam int FLG_GT   = 2;
  localparam int FLG_EQ   = 3;
  localparam int FLG_DIV0 = 4;
  localparam int FLG_UNK  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] CMPQ_NONE = 3'b000;
  localparam logic [2:0] CMPQ_GT   = 3'b001;
  localparam logic [2:0] CMPQ_LT   = 3'b010;
  localparam logic [2:0] CMPQ_NE   = 3'b011;
  localparam logic [2:0] CMPQ_EQ   = 3'b100;
  localparam logic [2:0] CMPQ_ALL  = 3'b111;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  // Qualifiers 000/011/111 always yield 0; others OR together the selected relations.
  function automatic logic cmp_select(input logic [2:0] qual, input logic gt,
                                      input logic lt, input logic eq);
    logic res;
    if (qual == CMPQ_NONE || qual == CMPQ_NE || qual == CMPQ_ALL) begin
      res = 1'b0;
    end else begin
      res = (qual[0] & gt) | (qual[1] & lt) | (qual[2] & eq);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | seq_alu_muldiv_iter: shift-add multiply / restoring divide      |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module seq_alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [CNT_W-1:0] cnt;
  logic             mode_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mode_r <= MD_MUL;
      hi_r   <= '0;
      lo_r   <= '0;
      opnd_r <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      mode_r <= mode;
      hi_r   <= '0;
      lo_r   <= (mode == MD_MUL) ? b : a;
      opnd_r <= (mode == MD_MUL) ? a : b;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      hi_r <= hi_nx;
      lo_r <= lo_nx;
    end
  end

  // {hi_r, lo_r} is the product/multiplier pair for MUL and remainder/dividend for DIV.
  always_comb begin
    sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : '0);
    trial = {hi_r, lo_r[WIDTH-1]};
    if (mode_r == MD_MUL) begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo_r[WIDTH-1:1]};
    end else if (trial >= {1'b0, opnd_r}) begin
      hi_nx = trial[WIDTH-1:0] - opnd_r;
      lo_nx = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = trial[WIDTH-1:0];
      lo_nx = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Outputs present the result of the step being taken, so the final step can be captured directly.
  assign done = (cnt == CNT_W'(1));
  assign lo   = lo_nx;
  assign hi   = hi_nx;

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------+
// | seq_alu: registered valid/ready ALU with iterative MUL/DIV      |
// | Optional z_hi port: SEQ_ALU_HIGH_RESULT_EN.  Revision: 1.0      |
// +----------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [7:0]       o_flags,
  output logic             busy
`ifdef SEQ_ALU_HIGH_RESULT_EN
  ,
  output logic [WIDTH-1:0] z_hi
`endif
);

  state_t             state;
  state_t             state_nx;
  logic [4:0]         opc;
  logic               accept;
  logic               is_iter;
  logic               calc_div;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] cl;
  logic [WIDTH-1:0]   sc_z;
  logic [WIDTH-1:0]   sc_hi;
  logic [7:0]         sc_flags;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_lo;
  logic [WIDTH-1:0]   iter_hi;

  assign opc       = op[4:0];
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_CALC);
  assign accept    = in_valid & in_ready;
  assign is_iter   = (opc == OP_MUL) | ((opc == OP_DIV) & (b != '0));

  seq_alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & is_iter),
    .mode  ((opc == OP_DIV) ? MD_DIV : MD_MUL),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    cl  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) cl = cl ^ ({{WIDTH{1'b0}}, a} << i);
    end
    sc_z     = '0;
    sc_hi    = '0;
    sc_flags = '0;
    case (opc)
      OP_ADD: begin
        sc_z              = sum[WIDTH-1:0];
        sc_flags[FLG_OVF] = sum[WIDTH];
      end
      OP_SUB: begin
        sc_z              = a - b;
        sc_flags[FLG_UNF] = (a < b);
      end
      OP_MUL: ;
      // Only the b==0 case finishes in a single cycle.
      OP_DIV: sc_flags[FLG_DIV0] = 1'b1;
      OP_CMP: begin
        sc_flags[FLG_GT] = (a > b);
        sc_flags[FLG_EQ] = (a == b);
        sc_z[0]          = cmp_select(op[7:5], a > b, a < b, a == b);
      end
      OP_AND:  sc_z = a & b;
      OP_OR:   sc_z = a | b;
      OP_XOR:  sc_z = a ^ b;
      OP_NOT:  sc_z = ~a;
      OP_NAND: sc_z = ~(a & b);
      OP_NOR:  sc_z = ~(a | b);
      OP_XNOR: sc_z = ~(a ^ b);
      OP_CL_MUL: begin
        sc_z              = cl[WIDTH-1:0];
        sc_hi             = cl[2*WIDTH-1:WIDTH];
        sc_flags[FLG_OVF] = |sc_hi;
      end
      default: sc_flags[FLG_UNK] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = is_iter ? ST_CALC : ST_DONE;
      ST_CALC: if (iter_done) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z        <= '0;
      o_flags  <= '0;
      calc_div <= 1'b0;
    end else if (accept && !is_iter) begin
      z       <= sc_z;
      o_flags <= sc_flags;
    end else if (accept) begin
      calc_div <= (opc == OP_DIV);
    end else if (state == ST_CALC && iter_done) begin
      z                <= iter_lo;
      o_flags          <= '0;
      o_flags[FLG_OVF] <= !calc_div && (|iter_hi);
    end
  end

`ifdef SEQ_ALU_HIGH_RESULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_hi <= '0;
    end else if (accept && !is_iter) begin
      z_hi <= sc_hi;
    end else if (state == ST_CALC && iter_done) begin
      z_hi <= iter_hi;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_seq_alu: randomized and directed checks of seq_alu (WIDTH=8) |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module tb_seq_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [7:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic [7:0]   o_flags;
  logic         busy;
`ifdef SEQ_ALU_HIGH_RESULT_EN
  logic [W-1:0] z_hi;
`endif

  int tests;
  int fails;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .o_flags   (o_flags),
    .busy      (busy)
`ifdef SEQ_ALU_HIGH_RESULT_EN
    ,
    .z_hi      (z_hi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic straight from the opcode rules.
  task automatic model(input int opv, input int av, input int bv,
                       output int ez, output int ef, output int ehi, output int elat);
    int opcode, q, p;
    opcode = opv % 32;
    q      = opv / 32;
    ez = 0; ef = 0; ehi = 0; elat = 1;
    case (opcode)
      0: begin p = av + bv; ez = p % 256; if (p > 255) ef = 1; end
      1: begin ez = (av - bv + 256) % 256; if (av < bv) ef = 2; end
      2: begin p = av * bv; ez = p % 256; ehi = p / 256; if (ehi != 0) ef = 1; elat = W + 1; end
      3: begin
        if (bv == 0) ef = 16;
        else begin ez = av / bv; ehi = av % bv; elat = W + 1; end
      end
      4: begin
        if (av > bv) ef += 4;
        if (av == bv) ef += 8;
        if (q == 0 || q == 3 || q == 7) ez = 0;
        else ez = ((q % 2 == 1) && av > bv) || (((q / 2) % 2 == 1) && av < bv)
                  || ((q / 4 == 1) && av == bv) ? 1 : 0;
      end
      5:  ez = av & bv;
      6:  ez = av | bv;
      7:  ez = av ^ bv;
      8:  ez = 255 - av;
      9:  ez = 255 - (av & bv);
      10: ez = 255 - (av | bv);
      11: ez = 255 - (av ^ bv);
      12: begin
        p = 0;
        for (int i = 0; i < W; i++) if (((bv >> i) & 1) == 1) p = p ^ (av << i);
        ez = p % 256; ehi = p / 256; if (ehi != 0) ef = 1;
      end
      default: ef = 32;
    endcase
  endtask

  // Runs one operation to completion and consumes it; returns the observations only.
  task automatic do_op(input logic [7:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input bit poke, output int rz, output int rf, output int rhi,
                       output int lat, output int bsy, output logic post_ov,
                       output logic post_ir);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; bsy = 0;
    while (!out_valid && lat < 50) begin
      if (busy) bsy++;
      if (poke && lat == 3) begin
        in_valid = 1'b1; op = 8'h00; a = 8'hFF; b = 8'hFF;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    rz = int'(z); rf = int'(o_flags);
`ifdef SEQ_ALU_HIGH_RESULT_EN
    rhi = int'(z_hi);
`else
    rhi = 0;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_ov = out_valid; post_ir = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (z !== 8'h00) begin fails++; $display("FAIL reset_z got %h want 00", z); end
    tests++; if (o_flags !== 8'h00) begin fails++; $display("FAIL reset_flags got %h want 00", o_flags); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  typedef struct {
    logic [7:0] o; logic [7:0] va; logic [7:0] vb; bit poke;
    int ez; int ef; int ehi; int elat; int ebsy;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    int rz, rf, rhi, lat, bsy;
    logic pov, pir;
    v[0] = '{8'h00, 8'd200, 8'd100, 1'b0, 'h2C, 'h01, 0, 1, 0};
    v[1] = '{8'h01, 8'd3,   8'd5,   1'b0, 'hFE, 'h02, 0, 1, 0};
    v[2] = '{8'h02, 8'd16,  8'd20,  1'b1, 'h40, 'h01, 1, 9, 8};
    v[3] = '{8'h03, 8'd100, 8'd7,   1'b0, 14,   0,    2, 9, 8};
    v[4] = '{8'h03, 8'd5,   8'd0,   1'b0, 0,    'h10, 0, 1, 0};
    v[5] = '{8'h84, 8'd9,   8'd9,   1'b0, 1,    'h08, 0, 1, 0};
    v[6] = '{8'h64, 8'd9,   8'd9,   1'b0, 0,    'h08, 0, 1, 0};
    v[7] = '{8'h1F, 8'd9,   8'd9,   1'b0, 0,    'h20, 0, 1, 0};
    v[8] = '{8'h0C, 8'h0F,  8'h0F,  1'b0, 'h55, 0,    0, 1, 0};
    v[9] = '{8'h07, 8'hF0,  8'h3C,  1'b0, 'hCC, 0,    0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      do_op(v[i].o, v[i].va, v[i].vb, v[i].poke, rz, rf, rhi, lat, bsy, pov, pir);
      tests++; if (rz != v[i].ez) begin fails++; $display("FAIL dir%0d_z got %h want %h", i, rz, v[i].ez); end
      tests++; if (rf != v[i].ef) begin fails++; $display("FAIL dir%0d_flags got %h want %h", i, rf, v[i].ef); end
      tests++; if (lat != v[i].elat) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].elat); end
      tests++; if (bsy != v[i].ebsy) begin fails++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bsy, v[i].ebsy); end
      tests++; if (pov !== 1'b0 || pir !== 1'b1) begin
        fails++; $display("FAIL dir%0d_consume got ov=%b ir=%b want ov=0 ir=1", i, pov, pir);
      end
`ifdef SEQ_ALU_HIGH_RESULT_EN
      tests++; if (rhi != v[i].ehi) begin fails++; $display("FAIL dir%0d_z_hi got %h want %h", i, rhi, v[i].ehi); end
`endif
    end
  endtask

  task automatic test_random();
    int rz, rf, rhi, lat, bsy, ez, ef, ehi, elat, opc, q, av, bv;
    logic pov, pir;
    for (int n = 0; n < 80; n++) begin
      opc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 31)) : int'($urandom_range(0, 12));
      q   = int'($urandom_range(0, 7));
      av  = int'($urandom_range(0, 255));
      bv  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      model(q * 32 + opc, av, bv, ez, ef, ehi, elat);
      do_op(8'(q * 32 + opc), 8'(av), 8'(bv), 1'b0, rz, rf, rhi, lat, bsy, pov, pir);
      tests++;
      if (rz != ez || rf != ef || lat != elat || bsy != elat - 1) begin
        fails++;
        $display("FAIL rnd op=%h a=%0d b=%0d got z=%h f=%h lat=%0d busy=%0d want z=%h f=%h lat=%0d busy=%0d",
                 q * 32 + opc, av, bv, rz, rf, lat, bsy, ez, ef, elat, elat - 1);
      end
`ifdef SEQ_ALU_HIGH_RESULT_EN
      tests++; if (rhi != ehi) begin fails++; $display("FAIL rnd_z_hi op=%h got %h want %h", q * 32 + opc, rhi, ehi); end
`endif
    end
  endtask

  task automatic test_backpressure();
    op = 8'h00; a = 8'd1; b = 8'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd50; b = 8'd60; op = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (z !== 8'd3 || o_flags !== 8'h00 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold%0d got z=%h f=%h ir=%b ov=%b want z=03 f=00 ir=0 ov=1",
                 i, z, o_flags, in_ready, out_valid);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL backpressure_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    op = 8'h02; a = 8'd16; b = 8'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (z !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || o_flags !== 8'h00) begin
      fails++; $display("FAIL midreset got z=%h ov=%b busy=%b f=%h want 00/0/0/00", z, out_valid, busy, o_flags);
    end
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk); #1;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL midreset_stale got %0d active cycles want 0", seen); end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_op();
    test_directed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
